// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter slice.
package mult_arb_pkg;

  // Encoding is {s2 valid, s1 valid} so the state can be rebuilt from the two stage flags.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    S1ONLY = 2'b01,
    S2ONLY = 2'b10,
    FULL   = 2'b11
  } occ_state_t;

  localparam int STALL_CNT_W = 16;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/carry_save_multiplier.sv
// Signed WIDTH x WIDTH array multiplier: partial-product rows reduced with
// carry-save adders, one carry-propagate add at the end. Purely combinational.
module Carry_Save_Multiplier #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] pp [WIDTH];
  logic [PW-1:0] s;
  logic [PW-1:0] c;
  logic [PW-1:0] t;

  // The sign bit of b carries negative weight, so its row is inverted and the +1
  // of the two's complement negation enters as the initial carry vector.
  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = b[i] ? (a_ext << i) : '0;
    end
    pp[WIDTH-1] = b[WIDTH-1] ? ~(a_ext << (WIDTH - 1)) : '0;
    s = pp[0];
    c = {{(PW-1){1'b0}}, b[WIDTH-1]};
    t = '0;
    for (int i = 1; i < WIDTH; i++) begin
      t = s ^ c ^ pp[i];
      c = ((s & c) | (s & pp[i]) | (c & pp[i])) << 1;
      s = t;
    end
    p = s + c;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = PW'((int'(idx) + 1) % N);
      end
    end
  end

  // The pointer only moves past a requester that actually completed a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// One shared signed multiplier, round-robin among NUM_REQ requesters, two-stage pipeline.
// Optional stall counter port enabled by defining MULT_SHARE_ARB_STALL_CNT_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH-1:0]       res_p,
  output logic [ID_W-1:0]          res_id
`ifdef MULT_SHARE_ARB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]   stall_cnt
`endif
);

  occ_state_t         occ;
  logic               s1_v;
  logic               s2_free;
  logic               s1_adv;
  logic               accept;
  logic               xfer;
  logic               s1_n;
  logic               s2_n;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [ID_W-1:0]    id_q;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [ID_W-1:0]    sel_id;
  logic [2*WIDTH-1:0] prod;

  assign s1_v      = (occ == S1ONLY) || (occ == FULL);
  assign res_valid = (occ == S2ONLY) || (occ == FULL);
  assign s2_free   = !res_valid || res_ready;
  assign s1_adv    = s1_v && s2_free;
  assign accept    = !s1_v || s1_adv;
  assign xfer      = |(req_valid & gnt);
  assign req_ready = gnt;
  assign s1_n      = xfer || (s1_v && !s1_adv);
  assign s2_n      = s1_adv || (res_valid && !res_ready);

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (accept && !rst),
    .advance (xfer),
    .gnt     (gnt)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_id = ID_W'(i);
      end
    end
  end

  Carry_Save_Multiplier #(
    .WIDTH(WIDTH)
  ) u_mult (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  // Reset drops both stages at once, so nothing in flight is ever presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= EMPTY;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      res_p  <= '0;
      res_id <= '0;
    end else begin
      if (xfer) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= sel_id;
      end
      if (s1_adv) begin
        res_p  <= prod;
        res_id <= id_q;
      end
      occ <= occ_state_t'({s2_n, s1_n});
    end
  end

`ifdef MULT_SHARE_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (res_valid && !res_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed products and ID orders.
module tb_mult_share_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_p;
  logic [IW-1:0]  res_id;
`ifdef MULT_SHARE_ARB_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  mult_share_arbiter #(
    .WIDTH   (W),
    .NUM_REQ (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id)
`ifdef MULT_SHARE_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             id;
    bit             vis;
  } item_t;

  typedef struct {
    logic [2*W-1:0] p;
    int             id;
  } out_t;

  item_t mq[$];
  out_t  outLog[$];
  out_t  obs;
  int    mPtr        = 0;
  int    mStall      = 0;
  int    xferCount   = 0;
  int    nCompared   = 0;
  int    nMismatched = 0;
  int    base;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model view: in-flight items in order; an item is visible once it has reached the output stage.
  function automatic bit headVis();
    return (mq.size() > 0) && mq[0].vis;
  endfunction

  function automatic bit s1Occ();
    return (mq.size() > 0) && !mq[mq.size()-1].vis;
  endfunction

  function automatic int expGrant();
    bit s2free;
    s2free = !headVis() || res_ready;
    if (rst || (s1Occ() && !s2free)) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(mPtr + k) % N]) return (mPtr + k) % N;
    end
    return -1;
  endfunction

  task automatic modelStep();
    int                g;
    bit                hv;
    bit                so;
    bit                s2free;
    logic signed [W-1:0] ta;
    logic signed [W-1:0] tb;
    item_t             it;
    if (rst) begin
      mq.delete();
      mPtr   = 0;
      mStall = 0;
      return;
    end
    g      = expGrant();
    hv     = headVis();
    so     = s1Occ();
    s2free = !hv || res_ready;
    if (hv && !res_ready && mStall < 65535) mStall++;
    if (hv && res_ready) void'(mq.pop_front());
    if (so && s2free) begin
      it     = mq.pop_back();
      it.vis = 1'b1;
      mq.push_back(it);
    end
    if (g >= 0) begin
      ta     = req_a[g*W +: W];
      tb     = req_b[g*W +: W];
      it.p   = 16'(int'(ta) * int'(tb));
      it.id  = g;
      it.vis = 1'b0;
      mq.push_back(it);
      mPtr = (g + 1) % N;
    end
  endtask

  task automatic checkOutput();
    int         g;
    logic [N-1:0] er;
    g  = expGrant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    checkVal("req_ready", 32'(req_ready), 32'(er));
    checkVal("res_valid", 32'(res_valid), 32'(headVis()));
    if (headVis()) begin
      checkVal("res_p", 32'(res_p), 32'(mq[0].p));
      checkVal("res_id", 32'(res_id), 32'(mq[0].id));
    end
`ifdef MULT_SHARE_ARB_STALL_CNT_EN
    checkVal("stall_cnt", 32'(stall_cnt), 32'(mStall));
`endif
  endtask

  always @(posedge clk) modelStep();

  always @(negedge clk) begin
    checkOutput();
    if ((req_valid & req_ready) != '0) xferCount++;
    if (!rst && res_valid && res_ready) begin
      obs.p  = res_p;
      obs.id = int'(res_id);
      outLog.push_back(obs);
    end
  end

  task automatic checkLog(input int idx, input string name, input logic [15:0] p, input int id);
    if (idx >= outLog.size()) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: result missing, got %0d results, expected index %0d", name, outLog.size(), idx);
    end else begin
      checkVal({name, " p"}, 32'(outLog[idx].p), 32'(p));
      checkVal({name, " id"}, 32'(outLog[idx].id), 32'(id));
    end
  endtask

  // Called just after a rising edge; holds the given inputs for the given number of edges.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] a,
                               input logic [N*W-1:0] b, input logic rr, input int cycles);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = rr;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkVal("reset res_valid", 32'(res_valid), 32'd0);
    checkVal("reset res_p", 32'(res_p), 32'd0);
    checkVal("reset res_id", 32'(res_id), 32'd0);
    checkVal("reset req_ready", 32'(req_ready), 32'd0);
    applyStimulus('0, '0, '0, 1'b1, 1);

    // Single requester 2: -3 * 5, result two edges after the transfer.
    base = outLog.size();
    applyStimulus(4'b0100, {8'h00, 8'hFD, 8'h00, 8'h00}, {8'h00, 8'h05, 8'h00, 8'h00}, 1'b1, 1);
    req_valid = '0;
    checkVal("t1 not yet valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    checkVal("t1 valid", 32'(res_valid), 32'd1);
    checkVal("t1 res_p", 32'(res_p), 32'h0000FFF1);
    checkVal("t1 res_id", 32'(res_id), 32'd2);
    applyStimulus('0, '0, '0, 1'b1, 3);
    checkLog(base, "t1 log", 16'hFFF1, 2);

    // Most-negative operand corners.
    base = outLog.size();
    applyStimulus(4'b0001, {24'h0, 8'h80}, {24'h0, 8'h80}, 1'b1, 1);
    applyStimulus(4'b0010, {16'h0, 8'h80, 8'h00}, {16'h0, 8'h7F, 8'h00}, 1'b1, 1);
    applyStimulus('0, '0, '0, 1'b1, 4);
    checkLog(base, "t2 min*min", 16'h4000, 0);
    checkLog(base + 1, "t2 min*max", 16'hC080, 1);

    // Requester 3 once, leaving the pointer back at 0.
    base = outLog.size();
    applyStimulus(4'b1000, {8'h02, 24'h0}, {8'h03, 24'h0}, 1'b1, 1);
    applyStimulus('0, '0, '0, 1'b1, 3);
    checkLog(base, "t2 filler", 16'h0006, 3);

    // All requesters continuously valid: one grant per cycle in rotation.
    base = outLog.size();
    applyStimulus(4'b1111, {8'hFF, 8'h7F, 8'hFB, 8'h03}, {8'hFF, 8'h80, 8'h06, 8'h04}, 1'b1, 6);
    applyStimulus('0, '0, '0, 1'b1, 4);
    checkVal("t3 count", 32'(outLog.size() - base), 32'd6);
    checkLog(base + 0, "t3 r0", 16'h000C, 0);
    checkLog(base + 1, "t3 r1", 16'hFFE2, 1);
    checkLog(base + 2, "t3 r2", 16'hC080, 2);
    checkLog(base + 3, "t3 r3", 16'h0001, 3);
    checkLog(base + 4, "t3 r4", 16'h000C, 0);
    checkLog(base + 5, "t3 r5", 16'hFFE2, 1);

    // Backpressure for six cycles with three requesters waiting.
    base      = outLog.size();
    xferCount = 0;
    applyStimulus(4'b0111, {8'h00, 8'h7F, 8'h10, 8'hF9}, {8'h00, 8'h7F, 8'h10, 8'h09}, 1'b0, 6);
    checkVal("t4 transfers", 32'(xferCount), 32'd2);
    checkVal("t4 ready blocked", 32'(req_ready), 32'd0);
    applyStimulus('0, '0, '0, 1'b1, 4);
    checkVal("t4 count", 32'(outLog.size() - base), 32'd2);
    checkLog(base, "t4 first", 16'h3F01, 2);
    checkLog(base + 1, "t4 second", 16'hFFC1, 0);

    // Fill the pipeline, then pulse reset while it is full.
    applyStimulus(4'b1010, {8'h20, 8'h00, 8'h11, 8'h00}, {8'h04, 8'h00, 8'h02, 8'h00}, 1'b0, 3);
    base      = outLog.size();
    rst       = 1'b1;
    req_a     = {8'h05, 8'h00, 8'h03, 8'h00};
    req_b     = {8'h05, 8'h00, 8'hFE, 8'h00};
    checkVal("t5 ready in rst", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    checkVal("t5 flushed", 32'(res_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    applyStimulus('0, '0, '0, 1'b1, 4);
    checkVal("t5 count", 32'(outLog.size() - base), 32'd2);
    checkLog(base, "t5 first", 16'hFFFA, 1);
    checkLog(base + 1, "t5 second", 16'h0019, 3);

    applyStimulus('0, '0, '0, 1'b1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
